mbist_march_ctrl: RTL

MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

---
 rtl/mbist_march_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- memory BIST controller driving an SRAM macro BIST port
// Issues one registered SRAM operation per cycle; read data is checked one cycle after its read.
module mbist_march_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              bist_en_o,
    output logic              bist_men_o,
    output logic              bist_wen_o,
    output logic              bist_ren_o,
    output logic [ADDR_W-1:0] bist_addr_o,
    output logic [DATA_W-1:0] bist_din_o,
    output logic [DATA_W-1:0] bist_bm_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              fail_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [7:0]        fail_cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic              phase_q, phase_d;
    logic              en_d, wen_d, ren_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] din_d, bm_d;
    logic              done_d, fail_d;
    logic [ADDR_W-1:0] fail_addr_d;
    logic [7:0]        fail_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;

    logic [2:0]        nxt_elem;
    logic              nxt_phase;
    logic [ADDR_W-1:0] nxt_addr;
    logic              two_op, down, at_end, last_op;
    logic [1:0]        op;

    // {is_read, data_bit} of the operation at (element, phase); phase 1 is the write of r/w pairs
    function automatic logic [1:0] op_decode(input logic [2:0] e, input logic p);
        case (e)
            3'd0:       op_decode = 2'b00;
            3'd1, 3'd3: op_decode = p ? 2'b01 : 2'b10;
            3'd2, 3'd4: op_decode = p ? 2'b00 : 2'b11;
            default:    op_decode = 2'b10;
        endcase
    endfunction

    always_comb begin
        two_op    = (elem_q >= 3'd1) && (elem_q <= 3'd4);
        down      = (elem_q >= 3'd3);
        at_end    = down ? (bist_addr_o == '0) : (bist_addr_o == ADDR_MAX);
        last_op   = (elem_q == 3'd5) && at_end;
        nxt_elem  = elem_q;
        nxt_phase = 1'b0;
        nxt_addr  = bist_addr_o;
        if (two_op && !phase_q) begin
            nxt_phase = 1'b1;
        end else if (at_end) begin
            nxt_elem = elem_q + 3'd1;
            nxt_addr = (elem_q >= 3'd2) ? ADDR_MAX : '0;
        end else if (down) begin
            nxt_addr = bist_addr_o - 1'b1;
        end else begin
            nxt_addr = bist_addr_o + 1'b1;
        end
        op = op_decode(nxt_elem, nxt_phase);
    end

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        phase_d     = phase_q;
        en_d        = 1'b0;
        wen_d       = 1'b0;
        ren_d       = 1'b0;
        addr_d      = '0;
        din_d       = '0;
        bm_d        = '0;
        done_d      = done_o;
        fail_d      = fail_o;
        fail_addr_d = fail_addr_o;
        fail_cnt_d  = fail_cnt_o;
        rd_pend_d   = 1'b0;
        exp_d       = exp_q;
        cmp_addr_d  = cmp_addr_q;

        if ((state_q == RUN || state_q == DRAIN) && !abort_i && rd_pend_q && (rdata_i != exp_q)) begin
            fail_d     = 1'b1;
            fail_cnt_d = (fail_cnt_o == 8'hFF) ? 8'hFF : fail_cnt_o + 8'd1;
            if (!fail_o) fail_addr_d = cmp_addr_q;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_i && !abort_i) begin
                    state_d     = RUN;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_cnt_d  = '0;
                    elem_d      = 3'd0;
                    phase_d     = 1'b0;
                    en_d        = 1'b1;
                    wen_d       = 1'b1;
                    bm_d        = '1;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    rd_pend_d  = bist_ren_o;
                    exp_d      = bist_din_o;
                    cmp_addr_d = bist_addr_o;
                    en_d       = 1'b1;
                    if (last_op) begin
                        state_d = DRAIN;
                    end else begin
                        elem_d  = nxt_elem;
                        phase_d = nxt_phase;
                        addr_d  = nxt_addr;
                        ren_d   = op[1];
                        wen_d   = !op[1];
                        din_d   = {DATA_W{op[0]}};
                        bm_d    = '1;
                    end
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            elem_q      <= '0;
            phase_q     <= 1'b0;
            bist_en_o   <= 1'b0;
            bist_men_o  <= 1'b0;
            bist_wen_o  <= 1'b0;
            bist_ren_o  <= 1'b0;
            bist_addr_o <= '0;
            bist_din_o  <= '0;
            bist_bm_o   <= '0;
            done_o      <= 1'b0;
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_cnt_o  <= '0;
            rd_pend_q   <= 1'b0;
            exp_q       <= '0;
            cmp_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            phase_q     <= phase_d;
            bist_en_o   <= en_d;
            bist_men_o  <= wen_d | ren_d;
            bist_wen_o  <= wen_d;
            bist_ren_o  <= ren_d;
            bist_addr_o <= addr_d;
            bist_din_o  <= din_d;
            bist_bm_o   <= bm_d;
            done_o      <= done_d;
            fail_o      <= fail_d;
            fail_addr_o <= fail_addr_d;
            fail_cnt_o  <= fail_cnt_d;
            rd_pend_q   <= rd_pend_d;
            exp_q       <= exp_d;
            cmp_addr_q  <= cmp_addr_d;
        end
    end

    assign busy_o = bist_en_o;

endmodule
